prog_loader: RTL and testbench
==============================

PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have port Clock, input, 1 bit: single system clock; all state changes on its rising edge.
REQ-002 SHALL have port Reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port Start, input, 1 bit: load request, sampled each cycle.
REQ-004 SHALL have port InValid, input, 1 bit: byte-stream valid.
REQ-005 SHALL have port InData, input, 8 bits: byte-stream data.
REQ-006 SHALL have port InReady, output, 1 bit: loader accepts the byte this cycle.
- A transfer occurs only when InValid=1 and InReady=1.
REQ-007 SHALL have port programEn, output, 1 bit: drives the CPU program-entry enable.
REQ-008 SHALL have port AddrSel, output, 5 bits: drives the CPU program-memory address.
REQ-009 SHALL have port Addrload, output, 1 bit: one-cycle address-load strobe to the CPU.
REQ-010 SHALL have port DataOut, output, 8 bits: drives the CPU Input bus.
REQ-011 SHALL have port PRload, output, 1 bit: one-cycle program-write strobe to the CPU.
REQ-012 SHALL have port CpuReset, output, 1 bit: one-cycle CPU reset pulse after a good load.
REQ-013 SHALL have port Done, output, 1 bit: last load succeeded.
REQ-014 SHALL have port Error, output, 1 bit: last load failed.

Function
REQ-015 SHALL accept the stream format: length byte N (1..32), then N program bytes for addresses 0..N-1, then one checksum byte equal to the sum of the N program bytes mod 256.
REQ-016 SHALL implement states IDLE, LEN, GETB, ADDR, WRITE, CHK, REL, DONE, ERR.
REQ-017 IDLE/DONE/ERR: Start=1 SHALL go to LEN, clear Done and Error, and set programEn=1.
- In every other state Start SHALL be ignored.
REQ-018 LEN: InReady=1; on transfer, N in 1..32 SHALL latch N, clear addr and sum, go to GETB.
- Any other length value SHALL go to ERR.
REQ-019 GETB: InReady=1; on transfer SHALL register the byte into DataOut, add it to sum (8-bit wrap), go to ADDR.
REQ-020 ADDR: SHALL assert Addrload=1 for exactly one cycle with AddrSel=addr, then go to WRITE.
REQ-021 WRITE: SHALL assert PRload=1 for exactly one cycle with DataOut and AddrSel held stable.
- If addr=N-1, SHALL go to CHK; otherwise SHALL increment addr and go to GETB.
REQ-022 CHK: InReady=1; on transfer, byte=sum SHALL go to REL; byte≠sum SHALL go to ERR.
REQ-023 REL: SHALL drive programEn=0 and CpuReset=1 for exactly one cycle, then go to DONE.
REQ-024 DONE: Done=1. ERR: Error=1, programEn=0, CpuReset never asserted.
REQ-025 InReady SHALL be 0 in IDLE, ADDR, WRITE, REL, DONE and ERR; bytes offered there SHALL be neither consumed nor lost by the source.
REQ-026 programEn SHALL be 1 continuously from LEN entry through CHK.
REQ-027 Addrload and PRload SHALL never be asserted in the same cycle.
REQ-028 With InValid held at 1, a load of N bytes SHALL take exactly 3N+3 cycles from LEN entry to DONE entry.
REQ-029 Program bytes 0..N-1 SHALL be written to ascending addresses 0..N-1 without gaps.
- addr SHALL never exceed 31 and SHALL never wrap.

Reset
REQ-030 Reset=1 SHALL asynchronously force IDLE, with InReady, programEn, Addrload, PRload, CpuReset, Done and Error at 0, and AddrSel, DataOut, N, addr and sum at 0.
REQ-031 Reset asserted mid-load SHALL abandon the load.
- CpuReset SHALL NOT pulse.
- After Reset falls, a new Start SHALL be required.

Structure
REQ-032 A shared package SHALL hold the state enumeration, MAX_WORDS=32, the address width 5 and the data width 8.
REQ-033 SHALL be a single module with no sub-modules; the FSM, addr counter, N register, sum accumulator and DataOut register SHALL be internal.

Verification
REQ-034 Start; stream 03,11,22,33,66 with InValid=1 -> PRload writes 11@0, 22@1, 33@2; one CpuReset pulse; Done=1 after 12 cycles.
REQ-035 Start; stream 02,AA,BB,00 -> checksum mismatch (65≠00) -> Error=1, CpuReset stays 0, programEn=0.
REQ-036 Length 00, then 21 (33) on a rerun -> ERR immediately each time; the data bytes that follow are not consumed (InReady=0).
REQ-037 N=32 with bytes 00..1F and checksum F0 -> last write at AddrSel=1F, Done=1, no address wrap.
REQ-038 InValid toggled randomly during N=4 -> identical writes and outcome; Start pulsed mid-load -> ignored.
REQ-039 Reset asserted during WRITE of byte 2 -> all outputs 0 immediately; no CpuReset; new Start reloads cleanly.

Source files
------------

// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: shared definitions for the program loader.
//   state_t   - loader FSM state encoding
//   MAX_WORDS - largest program length accepted (program memory depth)
//   ADDR_W    - program-memory address width
//   DATA_W    - byte/data width
//   CNT_W     - width wide enough to hold a length of MAX_WORDS
package prog_loader_pkg;

  localparam int unsigned MAX_WORDS = 32;
  localparam int unsigned ADDR_W    = 5;
  localparam int unsigned DATA_W    = 8;
  localparam int unsigned CNT_W     = ADDR_W + 1;

  typedef enum logic [3:0] {
    IDLE,
    LEN,
    GETB,
    ADDR,
    WRITE,
    CHK,
    REL,
    DONE,
    ERR
  } state_t;

endpackage

// File: rtl/prog_loader.sv
// prog_loader: receives a length-prefixed, checksummed byte stream and writes
// it into a CPU program memory, then releases the CPU with a reset pulse.
// Stream: length N (1..MAX_WORDS), N program bytes, checksum (sum mod 256).
// Ports:
//   Clock, Reset        - rising-edge clock, async active-high reset
//   Start               - load request (honoured only in IDLE/DONE/ERR)
//   InValid/InData      - byte stream in; InReady - byte accepted this cycle
//   programEn           - CPU program-entry enable, high from LEN through CHK
//   AddrSel/Addrload    - program address and its one-cycle load strobe
//   DataOut/PRload      - program byte and its one-cycle write strobe
//   CpuReset            - one-cycle CPU reset after a good load
//   Done/Error          - outcome of the last load
module prog_loader
  import prog_loader_pkg::*;
(
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Start,
  input  logic              InValid,
  input  logic [DATA_W-1:0] InData,
  output logic              InReady,
  output logic              programEn,
  output logic [ADDR_W-1:0] AddrSel,
  output logic              Addrload,
  output logic [DATA_W-1:0] DataOut,
  output logic              PRload,
  output logic              CpuReset,
  output logic              Done,
  output logic              Error
);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    n_q, n_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   sum_q, sum_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [CNT_W-1:0]    n_last;
  logic                len_ok;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      n_q     <= '0;
      addr_q  <= '0;
      sum_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      addr_q  <= addr_d;
      sum_q   <= sum_d;
      data_q  <= data_d;
    end
  end

  assign n_last = n_q - CNT_W'(1);
  assign len_ok = (InData != '0) && (InData <= DATA_W'(MAX_WORDS));

  // Next state. InReady is 1 in LEN/GETB/CHK, so InValid alone marks a
  // transfer there. addr only advances below N-1, so it can never wrap.
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    addr_d  = addr_q;
    sum_d   = sum_q;
    data_d  = data_q;
    unique case (state_q)
      IDLE, DONE, ERR: begin
        if (Start) state_d = LEN;
      end
      LEN: begin
        if (InValid) begin
          if (len_ok) begin
            n_d     = InData[CNT_W-1:0];
            addr_d  = '0;
            sum_d   = '0;
            state_d = GETB;
          end else begin
            state_d = ERR;
          end
        end
      end
      GETB: begin
        if (InValid) begin
          data_d  = InData;
          sum_d   = sum_q + InData;
          state_d = ADDR;
        end
      end
      ADDR:  state_d = WRITE;
      WRITE: begin
        if ({1'b0, addr_q} == n_last) begin
          state_d = CHK;
        end else begin
          addr_d  = addr_q + ADDR_W'(1);
          state_d = GETB;
        end
      end
      CHK: begin
        if (InValid) state_d = (InData == sum_q) ? REL : ERR;
      end
      REL:     state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // Moore outputs decoded from the state register, so reset clears them
  // immediately and strobes are exactly one cycle wide.
  always_comb begin
    InReady   = 1'b0;
    programEn = 1'b0;
    Addrload  = 1'b0;
    PRload    = 1'b0;
    CpuReset  = 1'b0;
    Done      = 1'b0;
    Error     = 1'b0;
    unique case (state_q)
      LEN, GETB, CHK: begin
        InReady   = 1'b1;
        programEn = 1'b1;
      end
      ADDR: begin
        programEn = 1'b1;
        Addrload  = 1'b1;
      end
      WRITE: begin
        programEn = 1'b1;
        PRload    = 1'b1;
      end
      REL:     CpuReset = 1'b1;
      DONE:    Done     = 1'b1;
      ERR:     Error    = 1'b1;
      default: ;
    endcase
  end

  assign AddrSel = addr_q;
  assign DataOut = data_q;

endmodule

// File: tb/tb_prog_loader.sv
module tb_prog_loader;

  logic       Clock = 1'b0;
  logic       Reset, Start, InValid;
  logic [7:0] InData;
  logic       InReady, programEn, Addrload, PRload, CpuReset, Done, Error;
  logic [4:0] AddrSel;
  logic [7:0] DataOut;

  prog_loader dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .InValid(InValid),
    .InData(InData), .InReady(InReady), .programEn(programEn),
    .AddrSel(AddrSel), .Addrload(Addrload), .DataOut(DataOut),
    .PRload(PRload), .CpuReset(CpuReset), .Done(Done), .Error(Error)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic [7:0]  bytes [0:34];
    int unsigned nbytes;
    bit          rand_valid;
    bit          start_mid;
    bit          exp_done;
    int unsigned leftover;
  } vector_t;

  vector_t     vec [7];
  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  logic [7:0]  src_q [$];
  logic [12:0] exp_q [$];
  bit          rand_valid = 1'b0;
  bit          hs = 1'b0;
  int unsigned cyc = 0, len_cyc = 0, done_cyc = 0, cpu_pulses = 0;
  logic        prev_al = 0, prev_pr = 0, prev_cr = 0, prev_pe = 0, prev_done = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Monitor: samples on the falling edge, checks every write against the
  // scoreboard and watches strobe widths.
  initial begin
    forever begin
      @(negedge Clock);
      cyc++;
      hs = InValid && InReady && !Reset;
      if (Addrload) begin
        check("al_pr_excl", {31'b0, PRload}, 0);
        check("al_width", {31'b0, prev_al}, 0);
      end
      if (PRload) begin
        check("pr_width", {31'b0, prev_pr}, 0);
        if (exp_q.size() == 0) begin
          check("pr_unexpected", 1, 0);
        end else begin
          logic [12:0] e;
          e = exp_q.pop_front();
          check("wr_addr", {27'b0, AddrSel}, {27'b0, e[12:8]});
          check("wr_data", {24'b0, DataOut}, {24'b0, e[7:0]});
        end
      end
      if (CpuReset) begin
        cpu_pulses++;
        check("cr_width", {31'b0, prev_cr}, 0);
      end
      if (programEn && !prev_pe) len_cyc = cyc;
      if (Done && !prev_done) done_cyc = cyc;
      prev_al = Addrload; prev_pr = PRload; prev_cr = CpuReset;
      prev_pe = programEn; prev_done = Done;
    end
  end

  // Byte source: offers src_q[0], pops it after a completed handshake.
  initial begin
    InValid = 1'b0;
    InData  = '0;
    forever begin
      @(posedge Clock);
      #1;
      if (hs && src_q.size() > 0) void'(src_q.pop_front());
      hs = 1'b0;
      if (src_q.size() > 0 && (!rand_valid || $urandom_range(0, 1) == 1)) begin
        InValid = 1'b1;
        InData  = src_q[0];
      end else begin
        InValid = 1'b0;
      end
    end
  end

  function automatic logic [19:0] outs();
    return {InReady, programEn, Addrload, PRload, CpuReset, Done, Error, AddrSel, DataOut};
  endfunction

  task automatic load_stream(input int idx);
    int unsigned l;
    l = vec[idx].bytes[0];
    exp_q.delete();
    src_q.delete();
    cpu_pulses = 0;
    rand_valid = vec[idx].rand_valid;
    if (l >= 1 && l <= 32)
      for (int i = 0; i < int'(l); i++) exp_q.push_back({5'(i), vec[idx].bytes[i+1]});
    for (int j = 0; j < int'(vec[idx].nbytes); j++) src_q.push_back(vec[idx].bytes[j]);
    @(posedge Clock); #1; Start = 1'b1;
    @(posedge Clock); #1; Start = 1'b0;
  endtask

  task automatic run_vec(input int idx);
    int unsigned l;
    bit          seen;
    l = vec[idx].bytes[0];
    seen = 1'b0;
    load_stream(idx);
    for (int k = 0; k < 2000; k++) begin
      @(negedge Clock);
      if (vec[idx].start_mid && k == 6) Start = 1'b1;
      else Start = 1'b0;
      if (Done || Error) begin
        seen = 1'b1;
        break;
      end
    end
    Start = 1'b0;
    check($sformatf("v%0d_finished", idx), {31'b0, seen}, 1);
    check($sformatf("v%0d_outcome", idx), {30'b0, Done, Error},
          {30'b0, vec[idx].exp_done, !vec[idx].exp_done});
    check($sformatf("v%0d_progen", idx), {31'b0, programEn}, 0);
    if (!vec[idx].rand_valid && vec[idx].exp_done)
      check($sformatf("v%0d_cycles", idx), done_cyc - len_cyc, 3 * l + 3);
    repeat (3) @(negedge Clock);
    check($sformatf("v%0d_inready", idx), {31'b0, InReady}, 0);
    check($sformatf("v%0d_cpureset", idx), cpu_pulses, {31'b0, vec[idx].exp_done});
    check($sformatf("v%0d_writes_left", idx), exp_q.size(), 0);
    check($sformatf("v%0d_bytes_left", idx), src_q.size(), vec[idx].leftover);
    check($sformatf("v%0d_held", idx), {30'b0, Done, Error},
          {30'b0, vec[idx].exp_done, !vec[idx].exp_done});
    src_q.delete();
  endtask

  initial begin
    bit hit;
    Reset = 1'b1;
    Start = 1'b0;
    foreach (vec[i]) begin
      foreach (vec[i].bytes[j]) vec[i].bytes[j] = '0;
      vec[i].rand_valid = 0; vec[i].start_mid = 0; vec[i].leftover = 0;
    end
    // 0: basic N=3 load
    vec[0].bytes[0:4] = '{8'h03, 8'h11, 8'h22, 8'h33, 8'h66};
    vec[0].nbytes = 5; vec[0].exp_done = 1;
    // 1: checksum mismatch (sum 65)
    vec[1].bytes[0:3] = '{8'h02, 8'hAA, 8'hBB, 8'h00};
    vec[1].nbytes = 4; vec[1].exp_done = 0;
    // 2: length 0, following bytes stay unconsumed
    vec[2].bytes[0:2] = '{8'h00, 8'h01, 8'h02};
    vec[2].nbytes = 3; vec[2].exp_done = 0; vec[2].leftover = 2;
    // 3: length 33
    vec[3].bytes[0:1] = '{8'h21, 8'h05};
    vec[3].nbytes = 2; vec[3].exp_done = 0; vec[3].leftover = 1;
    // 4: full-depth load, bytes 00..1F, checksum F0
    vec[4].bytes[0] = 8'h20;
    for (int i = 0; i < 32; i++) vec[4].bytes[i+1] = 8'(i);
    vec[4].bytes[33] = 8'hF0;
    vec[4].nbytes = 34; vec[4].exp_done = 1;
    // 5: N=4, random InValid gaps and a stray Start mid-load
    vec[5].bytes[0:5] = '{8'h04, 8'h10, 8'h20, 8'h30, 8'h40, 8'hA0};
    vec[5].nbytes = 6; vec[5].exp_done = 1; vec[5].rand_valid = 1; vec[5].start_mid = 1;
    // 6: minimum length
    vec[6].bytes[0:2] = '{8'h01, 8'hFF, 8'hFF};
    vec[6].nbytes = 3; vec[6].exp_done = 1;

    repeat (3) @(posedge Clock);
    #1;
    check("reset_outputs", {12'b0, outs()}, 0);
    Reset = 1'b0;
    repeat (2) @(negedge Clock);
    check("idle_outputs", {12'b0, outs()}, 0);

    foreach (vec[i]) run_vec(i);

    // Reset during the write of byte 2 abandons the load.
    load_stream(0);
    hit = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge Clock);
      if (PRload && AddrSel == 5'd2) begin
        hit = 1'b1;
        break;
      end
    end
    check("rst_reached_write2", {31'b0, hit}, 1);
    #2 Reset = 1'b1;
    #1 check("rst_async_outputs", {12'b0, outs()}, 0);
    src_q.delete();
    exp_q.delete();
    repeat (2) @(posedge Clock);
    #1 Reset = 1'b0;
    repeat (4) @(negedge Clock);
    check("rst_stays_idle", {12'b0, outs()}, 0);
    check("rst_no_cpureset", cpu_pulses, 0);

    run_vec(0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
